fifo_bank_sched: RTL and testbench

- Controller that shares the MMIO write path among a bank of shift-register FIFOs (same shape as the existing `fifo`: `clk`, `rst_n`, `en`, `d`, `q`), then sequences a synchronous drain of the whole bank.
- Sits between the AFU's MMIO write decode and the FIFO instances.
- Owns per-FIFO fill accounting, load/start/clear command handling, error flags and a status word that the AFU returns on MMIO reads.

---
 rtl/fifo_bank_sched.sv | 171 +++++++++++++++++
 tb/tb_fifo_bank_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_bank_sched.sv
// fifo_bank_sched: shares the MMIO write path across a bank of shift-register
// FIFOs, tracks per-FIFO fill levels and runs a synchronous drain of the bank.
module fifo_bank_sched #(
   parameter int unsigned       NUM_FIFOS = 8,
   parameter int unsigned       DEPTH     = 8,
   parameter int unsigned       DATA_W    = 64,
   parameter logic [15:0]       BASE_ADDR = 16'h0040
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_valid,
   input  logic [15:0]          wr_addr,
   input  logic [DATA_W-1:0]    wr_data,
   output logic [NUM_FIFOS-1:0] fifo_en,
   output logic [DATA_W-1:0]    fifo_d,
   output logic                 drain_valid,
   output logic                 busy,
   output logic                 done,
   output logic [63:0]          status
);

   localparam int unsigned CW      = $clog2(DEPTH + 1);
   localparam logic [3:0]  DEPTH_C = 4'(DEPTH);
   localparam logic [15:0] CTRL_A  = BASE_ADDR + 16'h0010;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                     r_state, w_state_nxt;
   logic [NUM_FIFOS-1:0][3:0]  r_fill, w_fill_nxt;
   logic [CW-1:0]              r_cnt, w_cnt_nxt;
   logic                       r_ovf, w_ovf_nxt;
   logic                       r_start_err, w_start_err_nxt;
   logic                       r_busy_err, w_busy_err_nxt;
   logic [NUM_FIFOS-1:0]       r_fifo_en, w_en_nxt;
   logic [DATA_W-1:0]          r_fifo_d, w_d_nxt;
   logic                       r_drain_valid, r_busy, r_done;
   logic [63:0]                r_status, w_status_nxt;

   logic [NUM_FIFOS-1:0]       w_load_hit;
   logic                       w_load_any, w_ctrl_hit, w_clear, w_start, w_all_full;

   // Address decode of the incoming MMIO write.
   always_comb begin
      w_load_hit = '0;
      w_all_full = 1'b1;
      for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
         w_load_hit[i] = wr_valid && (wr_addr == BASE_ADDR + 16'(2 * i));
         if (r_fill[i] != DEPTH_C) w_all_full = 1'b0;
      end
      w_load_any = |w_load_hit;
      w_ctrl_hit = wr_valid && (wr_addr == CTRL_A);
      w_clear    = w_ctrl_hit && wr_data[1];
      w_start    = w_ctrl_hit && wr_data[0] && !wr_data[1];
   end

   // Next-state, fill accounting, error flags and shift-enable generation.
   always_comb begin
      w_state_nxt     = r_state;
      w_fill_nxt      = r_fill;
      w_cnt_nxt       = r_cnt;
      w_ovf_nxt       = r_ovf;
      w_start_err_nxt = r_start_err;
      w_busy_err_nxt  = r_busy_err;
      w_en_nxt        = '0;
      w_d_nxt         = r_fifo_d;
      if (w_clear) begin
         w_state_nxt     = ST_IDLE;
         w_fill_nxt      = '0;
         w_cnt_nxt       = '0;
         w_ovf_nxt       = 1'b0;
         w_start_err_nxt = 1'b0;
         w_busy_err_nxt  = 1'b0;
      end else if (r_state == ST_DRAIN) begin
         if (w_load_any || w_start) w_busy_err_nxt = 1'b1;
         // r_cnt holds the drain cycles still to run including the current one.
         if (r_cnt == CW'(1)) begin
            w_state_nxt = ST_DONE;
            w_fill_nxt  = '0;
            w_cnt_nxt   = '0;
         end else begin
            w_cnt_nxt = r_cnt - CW'(1);
            for (int unsigned i = 0; i < NUM_FIFOS; i++)
               w_fill_nxt[i] = r_fill[i] - 4'd1;
            w_en_nxt = '1;
            w_d_nxt  = '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            if (w_load_hit[i]) begin
               if (r_fill[i] < DEPTH_C) begin
                  w_fill_nxt[i] = r_fill[i] + 4'd1;
                  w_en_nxt[i]   = 1'b1;
                  w_d_nxt       = wr_data;
                  w_state_nxt   = ST_LOAD;
               end else begin
                  w_ovf_nxt = 1'b1;
               end
            end
         end
         if (w_start) begin
            if (r_state == ST_LOAD && w_all_full) begin
               w_state_nxt = ST_DRAIN;
               w_cnt_nxt   = CW'(DEPTH);
               w_en_nxt    = '1;
               w_d_nxt     = '0;
            end else begin
               w_start_err_nxt = 1'b1;
            end
         end
      end
   end

   // Status word assembled from next-cycle values so it lands with the event.
   always_comb begin
      w_status_nxt      = '0;
      w_status_nxt[1:0] = w_state_nxt;
      w_status_nxt[2]   = w_ovf_nxt;
      w_status_nxt[3]   = w_start_err_nxt;
      w_status_nxt[4]   = w_busy_err_nxt;
      for (int unsigned i = 0; i < NUM_FIFOS; i++)
         w_status_nxt[8 + 4 * i +: 4] = w_fill_nxt[i];
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Datapath and registered output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fill        <= '0;
         r_cnt         <= '0;
         r_ovf         <= 1'b0;
         r_start_err   <= 1'b0;
         r_busy_err    <= 1'b0;
         r_fifo_en     <= '0;
         r_fifo_d      <= '0;
         r_drain_valid <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_status      <= '0;
      end else begin
         r_fill        <= w_fill_nxt;
         r_cnt         <= w_cnt_nxt;
         r_ovf         <= w_ovf_nxt;
         r_start_err   <= w_start_err_nxt;
         r_busy_err    <= w_busy_err_nxt;
         r_fifo_en     <= w_en_nxt;
         r_fifo_d      <= w_d_nxt;
         r_drain_valid <= (w_state_nxt == ST_DRAIN);
         r_busy        <= (w_state_nxt == ST_DRAIN);
         r_done        <= (w_state_nxt == ST_DONE);
         r_status      <= w_status_nxt;
      end
   end

   assign fifo_en     = r_fifo_en;
   assign fifo_d      = r_fifo_d;
   assign drain_valid = r_drain_valid;
   assign busy        = r_busy;
   assign done        = r_done;
   assign status      = r_status;

endmodule

// File: tb/tb_fifo_bank_sched.sv
// Directed bench for fifo_bank_sched with a cycle-level reference model.
module tb_fifo_bank_sched;

   localparam int unsigned NF = 8;
   localparam int unsigned DP = 8;
   localparam int unsigned DW = 64;
   localparam logic [15:0] BA = 16'h0040;
   localparam logic [15:0] CA = 16'h0050;

   logic          clk, rst_n, wr_valid;
   logic [15:0]   wr_addr;
   logic [DW-1:0] wr_data;
   logic [NF-1:0] fifo_en;
   logic [DW-1:0] fifo_d;
   logic          drain_valid, busy, done;
   logic [63:0]   status;

   fifo_bank_sched #(.NUM_FIFOS(NF), .DEPTH(DP), .DATA_W(DW), .BASE_ADDR(BA)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_addr(wr_addr),
      .wr_data(wr_data), .fifo_en(fifo_en), .fifo_d(fifo_d),
      .drain_valid(drain_valid), .busy(busy), .done(done), .status(status)
   );

   int n_err = 0;
   int n_checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: state 0..3, fill levels, sticky errors, drain cycles left.
   int            m_state = 0;
   int            m_fill[NF];
   bit            m_ovf = 0, m_se = 0, m_be = 0;
   int            m_left = 0;
   logic [NF-1:0] m_en = '0;
   logic [DW-1:0] m_d = '0;

   task automatic model_reset();
      m_state = 0; m_ovf = 0; m_se = 0; m_be = 0; m_left = 0;
      m_en = '0; m_d = '0;
      foreach (m_fill[i]) m_fill[i] = 0;
   endtask

   function automatic logic [63:0] m_status();
      logic [63:0] s;
      s = 64'(m_state) | (64'(m_ovf) << 2) | (64'(m_se) << 3) | (64'(m_be) << 4);
      for (int i = 0; i < NF; i++) s = s | (64'(m_fill[i]) << (8 + 4 * i));
      return s;
   endfunction

   task automatic model_step();
      bit is_ctrl, is_load, all_full;
      int idx;
      is_ctrl = wr_valid && wr_addr == CA;
      is_load = wr_valid && wr_addr >= BA && wr_addr < BA + 16'(2 * NF) && !wr_addr[0];
      idx     = int'(wr_addr - BA) / 2;
      m_en    = '0;
      if (is_ctrl && wr_data[1]) begin
         m_state = 0; m_ovf = 0; m_se = 0; m_be = 0; m_left = 0;
         foreach (m_fill[i]) m_fill[i] = 0;
      end else if (m_state == 2) begin
         if (is_load || (is_ctrl && wr_data[0])) m_be = 1;
         m_left--;
         if (m_left == 0) begin
            m_state = 3;
            foreach (m_fill[i]) m_fill[i] = 0;
         end else begin
            foreach (m_fill[i]) m_fill[i]--;
            m_en = '1; m_d = '0;
         end
      end else begin
         if (is_load) begin
            if (m_fill[idx] < DP) begin
               m_fill[idx]++; m_en[idx] = 1'b1; m_d = wr_data; m_state = 1;
            end else m_ovf = 1;
         end
         if (is_ctrl && wr_data[0]) begin
            all_full = 1;
            foreach (m_fill[i]) if (m_fill[i] != DP) all_full = 0;
            if (m_state == 1 && all_full) begin
               m_state = 2; m_left = DP; m_en = '1; m_d = '0;
            end else m_se = 1;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("m_fifo_en", 64'(fifo_en), 64'(m_en));
         chk("m_fifo_d", fifo_d, m_d);
         chk("m_drain_valid", 64'(drain_valid), 64'(m_state == 2));
         chk("m_busy", 64'(busy), 64'(m_state == 2));
         chk("m_done", 64'(done), 64'(m_state == 3));
         chk("m_status", status, m_status());
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic wr(input logic [15:0] a, input logic [DW-1:0] d);
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic fill_all();
      for (int i = 0; i < NF; i++)
         for (int k = 0; k < DP; k++)
            wr(BA + 16'(2 * i), DW'(32'h100 * i + k));
   endtask

   initial begin
      int c;
      rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      idle(3);
      chk("rst_status", status, 64'h0);
      chk("rst_en", 64'(fifo_en), 64'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      idle(1);

      // Fill and drain
      fill_all();
      idle(1);
      chk("fill_status", status, 64'h0000_0088_8888_8801);
      wr(CA, 64'h1);
      chk("drain_first_dv", 64'(drain_valid), 64'h1);
      chk("drain_first_en", 64'(fifo_en), 64'hFF);
      c = 0;
      for (int j = 0; j < 12; j++) begin
         if (drain_valid) c++;
         idle(1);
      end
      chk("drain_len", 64'(c), 64'd8);
      chk("drain_done", 64'(done), 64'h1);
      chk("drain_status", status, 64'h3);

      // Overflow
      wr(CA, 64'h2);
      c = 0;
      for (int j = 0; j < 9; j++) begin
         wr(16'h0042, DW'(j));
         if (fifo_en[1]) c++;
      end
      chk("ovf_pulses", 64'(c), 64'd8);
      chk("ovf_status", status, 64'h8005);

      // Early start, plus unmatched and odd addresses
      wr(CA, 64'h2);
      for (int k = 0; k < 8; k++) wr(16'h0040, DW'(k));
      wr(16'h0041, 64'h77);
      wr(16'h0052, 64'h77);
      wr(CA, 64'h1);
      chk("early_dv", 64'(drain_valid), 64'h0);
      chk("early_status", status, 64'h809);

      // Busy writes during drain
      wr(CA, 64'h2);
      fill_all();
      wr(CA, 64'h1);
      c = 0;
      for (int j = 0; j < 12; j++) begin
         if (drain_valid) c++;
         if (j == 2)      wr(16'h0044, 64'hAA);
         else if (j == 3) wr(CA, 64'h1);
         else             idle(1);
      end
      chk("busy_len", 64'(c), 64'd8);
      chk("busy_status", status, 64'h13);

      // Clear abort on 3rd drain cycle
      wr(CA, 64'h2);
      fill_all();
      wr(CA, 64'h1);
      idle(1);
      wr(CA, 64'h3);
      chk("clr_en", 64'(fifo_en), 64'h0);
      chk("clr_dv", 64'(drain_valid), 64'h0);
      chk("clr_status", status, 64'h0);
      chk("clr_done", 64'(done), 64'h0);
      idle(2);

      // Reset mid-drain
      fill_all();
      wr(CA, 64'h1);
      idle(2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_en", 64'(fifo_en), 64'h0);
      chk("arst_dv", 64'(drain_valid), 64'h0);
      chk("arst_busy", 64'(busy), 64'h0);
      chk("arst_status", status, 64'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      idle(1);
      chk("post_rst_status", status, 64'h0);
      wr(16'h0040, 64'h5);
      chk("post_rst_load", status, 64'h101);
      chk("post_rst_d", fifo_d, 64'h5);
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
